// File: rtl/gpio_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_seq_pkg
// Purpose  : Shared definitions for the GPIO sequencer port: register byte
//            offsets, CTRL bit positions, bring-up table length, the table
//            itself and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_seq_pkg;

  // Register byte offsets inside the 32-byte window
  localparam logic [4:0] ADDR_DATA = 5'h00;
  localparam logic [4:0] ADDR_OEB  = 5'h04;
  localparam logic [4:0] ADDR_CTRL = 5'h08;
  localparam logic [4:0] ADDR_DIV  = 5'h0C;
  localparam logic [4:0] ADDR_IN   = 5'h10;

  // CTRL bit positions
  localparam int CTRL_SEQ_EN = 0;
  localparam int CTRL_DONE   = 1;

  // Bring-up pattern: 01..0A, FF, 00
  localparam int         SEQ_LEN  = 12;
  localparam logic [3:0] SEQ_LAST = 4'(SEQ_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  function automatic logic [7:0] seq_value(input logic [3:0] idx);
    logic [7:0] v;
    if (idx < 4'd10)       v = {4'h0, idx} + 8'd1;
    else if (idx == 4'd10) v = 8'hFF;
    else                   v = 8'h00;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : gpio_seq_gen
// Purpose  : Pattern sequencer. Walks the bring-up table, holding each entry
//            for div+1 cycles, then reports completion.
// Ports    : clock, resetb (sync, active-low)
//            start  - begin a run from entry 0 (ignored while running)
//            abort  - return to idle without loading a new value
//            div    - hold count per entry minus one, sampled every compare
//            value  - table value to load when load is high
//            load   - single-cycle strobe: pin data register takes value
//            done   - single-cycle strobe: final entry has been held
// Revision : 1.0 - initial release
// ============================================================================
module gpio_seq_gen (
  input  logic        clock,
  input  logic        resetb,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] div,
  output logic [7:0]  value,
  output logic        load,
  output logic        done
);
  import gpio_seq_pkg::*;

  seq_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    value   = seq_value(idx_q);
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 4'd0;
          cnt_d   = 16'd0;
          value   = seq_value(4'd0);
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        // >= rather than == so a DIV lowered below the running count
        // still wraps at the next compare instead of rolling over 16 bits.
        end else if (cnt_q >= div) begin
          cnt_d = 16'd0;
          if (idx_q == SEQ_LAST) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            value = seq_value(idx_q + 4'd1);
            load  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gpio_seq_port.sv
`default_nettype none
// ============================================================================
// Module   : gpio_seq_port
// Purpose  : Wishbone-classic GPIO port for the low user pins, with a
//            hardware sequencer that plays the bring-up pattern.
// Ports    : clock, resetb (sync, active-low)
//            wbs_*          - Wishbone classic slave
//            io_in          - pad input values
//            io_out/io_oeb  - pad output values / active-low output enables
// Config   : GPIO_READBACK_EN - when defined, the IN register returns io_in
//            through a 2-flop synchroniser; otherwise IN reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_seq_port #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_W      = 8,
  parameter logic [15:0] DIV_RST   = 16'd1000
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);
  import gpio_seq_pkg::*;

  logic [IO_W-1:0] data_q, data_d;
  logic [IO_W-1:0] oeb_q, oeb_d;
  logic [15:0]     div_q, div_d;
  logic            seq_en_q, seq_en_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;

  logic            req;
  logic            wr;
  logic [4:0]      off;
  logic [31:0]     rdata;
  logic [IO_W-1:0] in_val;
  logic            seq_start;
  logic            seq_abort;
  logic [7:0]      seq_value_w;
  logic            seq_load;
  logic            seq_done;

  // Suppressing a request in the cycle after an ack keeps the still-asserted
  // strobe from producing a second ack for the same transfer.
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q &
               (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign wr  = req & wbs_we_i;
  assign off = {wbs_adr_i[4:2], 2'b00};

`ifdef GPIO_READBACK_EN
  logic [IO_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  assign in_val = sync2_q;
`else
  logic unused_io_in;
  assign unused_io_in = ^io_in;
  assign in_val       = '0;
`endif

  logic unused_wb_bits;
  assign unused_wb_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  always_comb begin
    rdata = 32'd0;
    case (off)
      ADDR_DATA: rdata = 32'(data_q);
      ADDR_OEB:  rdata = 32'(oeb_q);
      ADDR_CTRL: rdata = {30'd0, done_q, seq_en_q};
      ADDR_DIV:  rdata = {16'd0, div_q};
      ADDR_IN:   rdata = 32'(in_val);
      default:   rdata = 32'd0;
    endcase
  end

  always_comb begin
    data_d    = data_q;
    oeb_d     = oeb_q;
    div_d     = div_q;
    seq_en_d  = seq_en_q;
    done_d    = done_q;
    ack_d     = req;
    dat_d     = req ? rdata : 32'd0;
    seq_start = 1'b0;
    seq_abort = 1'b0;

    if (wr) begin
      case (off)
        ADDR_DATA: if (wbs_sel_i[0] && !seq_en_q) data_d = wbs_dat_i[IO_W-1:0];
        ADDR_OEB:  if (wbs_sel_i[0]) oeb_d = wbs_dat_i[IO_W-1:0];
        ADDR_DIV: begin
          if (wbs_sel_i[0]) div_d[7:0]  = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) div_d[15:8] = wbs_dat_i[15:8];
        end
        ADDR_CTRL: begin
          if (wbs_sel_i[0]) begin
            if (wbs_dat_i[CTRL_DONE]) done_d = 1'b0;
            if (wbs_dat_i[CTRL_SEQ_EN] && !seq_en_q) begin
              seq_start = 1'b1;
              seq_en_d  = 1'b1;
            end else if (!wbs_dat_i[CTRL_SEQ_EN] && seq_en_q) begin
              seq_abort = 1'b1;
              seq_en_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end

    if (seq_load) data_d = IO_W'(seq_value_w);

    // Completion is applied last so it wins over a same-cycle DONE clear.
    if (seq_done) begin
      seq_en_d = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      data_q   <= '0;
      oeb_q    <= '1;
      div_q    <= DIV_RST;
      seq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
    end else begin
      data_q   <= data_d;
      oeb_q    <= oeb_d;
      div_q    <= div_d;
      seq_en_q <= seq_en_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  gpio_seq_gen u_gen (
    .clock  (clock),
    .resetb (resetb),
    .start  (seq_start),
    .abort  (seq_abort),
    .div    (div_q),
    .value  (seq_value_w),
    .load   (seq_load),
    .done   (seq_done)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = data_q;
  assign io_oeb    = seq_en_q ? '0 : oeb_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_seq_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_seq_port
// Purpose  : Self-checking bench for gpio_seq_port. Read responses are
//            queued by the stimulus and checked by an independent monitor;
//            pin values are compared against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_seq_port;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        resetb;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  io_in, io_out, io_oeb;

  always #5 clock = ~clock;

  gpio_seq_port #(
    .BASE_ADDR (BASE),
    .IO_W      (8),
    .DIV_RST   (16'd1000)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: one entry per expected ack; chk_q says whether data is checked
  logic [31:0] exp_q[$];
  bit          chk_q[$];

  // Register-level model
  logic [7:0]  m_data, m_oeb, m_in;
  logic [15:0] m_div;
  logic        m_seq, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] tbl(input int k);
    if (k < 10)  return 8'(k + 1);
    if (k == 10) return 8'hFF;
    return 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input int word);
    case (word)
      0: return {24'd0, m_data};
      1: return {24'd0, m_oeb};
      2: return {30'd0, m_done, m_seq};
      3: return {16'd0, m_div};
`ifdef GPIO_READBACK_EN
      4: return {24'd0, m_in};
`else
      4: return 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_oeb = 8'hFF; m_div = 16'd1000; m_seq = 1'b0; m_done = 1'b0;
  endtask

  // Monitor: independent of stimulus, runs on every falling edge
  logic prev_ack = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (wbs_ack_o === 1'b1) begin
        check("ack_width", {31'd0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          bit          c;
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          if (c) check("rdata", wbs_dat_o, e);
        end
      end else begin
        check("dat_idle_zero", wbs_dat_o, 32'd0);
      end
      prev_ack = (wbs_ack_o === 1'b1);
    end
  end

  // One Wishbone transfer; returns on the falling edge where ack is seen
  task automatic wb(input bit we, input int word, input logic [31:0] dat,
                    input logic [3:0] sel, input logic [31:0] exp);
    bit got = 0;
    @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = BASE + 32'(word * 4); wbs_dat_i = dat; wbs_sel_i = sel;
    exp_q.push_back(exp);
    chk_q.push_back(!we);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (wbs_ack_o === 1'b1) begin got = 1; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) begin void'(exp_q.pop_back()); void'(chk_q.pop_back()); end
    end
  endtask

  task automatic rd(input int word);
    wb(1'b0, word, 32'd0, 4'hF, model_read(word));
  endtask

  task automatic pins(input string tag);
    check({tag, "_io_out"}, {24'd0, io_out}, {24'd0, m_data});
    check({tag, "_io_oeb"}, {24'd0, io_oeb}, {24'd0, m_seq ? 8'h00 : m_oeb});
  endtask

  // Full run: every entry held div+1 cycles, then DONE and pins released
  task automatic run_full(input int d);
    wb(1'b1, 2, 32'd1, 4'hF, 32'd0);
    m_seq = 1'b1;
    for (int k = 0; k < 12 * (d + 1); k++) begin
      m_data = tbl(k / (d + 1));
      pins("seq");
      @(negedge clock);
    end
    m_data = 8'h00; m_seq = 1'b0; m_done = 1'b1;
    pins("seq_end");
    rd(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    resetb = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; io_in = 8'h00; m_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    resetb = 1'b1;

    // Reset state
    pins("reset");
    rd(3);
    rd(2);

    // Unmapped address: no ack
    @(negedge clock);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE + 32'h20;
    wbs_dat_i = 32'hFF; wbs_sel_i = 4'hF;
    saw = 0;
    repeat (4) begin @(negedge clock); if (wbs_ack_o === 1'b1) saw = 1; end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    check("miss_ack", {31'd0, saw}, 32'd0);

    // Direct writes and byte selects
    wb(1'b1, 1, 32'h00, 4'hF, 0); m_oeb = 8'h00;
    wb(1'b1, 0, 32'h5A, 4'b0001, 0); m_data = 8'h5A;
    pins("direct");
    wb(1'b1, 0, 32'h33, 4'b0010, 0);
    pins("sel_masked");
    wb(1'b1, 1, 32'hC3, 4'hF, 0); m_oeb = 8'hC3;

    // Full sequence with DIV=3
    wb(1'b1, 3, 32'd3, 4'hF, 0); m_div = 16'd3;
    run_full(3);

    // DONE W1C
    wb(1'b1, 2, 32'd2, 4'hF, 0); m_done = 1'b0;
    rd(2);

    // DIV=0 run aborted while 05 is on the pins
    wb(1'b1, 3, 32'd0, 4'hF, 0); m_div = 16'd0;
    wb(1'b1, 2, 32'd1, 4'hF, 0); m_seq = 1'b1;
    repeat (3) @(negedge clock);
    wb(1'b1, 2, 32'd0, 4'hF, 0); m_seq = 1'b0; m_data = tbl(4);
    pins("abort");
    rd(2);

    // Reset mid-run at value 07 with DIV=1
    wb(1'b1, 3, 32'd1, 4'hF, 0); m_div = 16'd1;
    wb(1'b1, 2, 32'd1, 4'hF, 0); m_seq = 1'b1;
    repeat (12) @(negedge clock);
    m_data = tbl(6);
    pins("pre_reset");
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    model_reset();
    pins("mid_reset");
    rd(3);

    // IN register
    io_in = 8'hA5; m_in = 8'hA5;
    repeat (2) @(negedge clock);
    rd(4);

    // Randomized register traffic
    for (int it = 0; it < 40; it++) begin
      int          op;
      logic [31:0] v;
      logic [3:0]  s;
      op = $urandom_range(0, 4);
      v  = $urandom;
      s  = 4'($urandom_range(0, 15));
      case (op)
        0: begin wb(1'b1, 0, v, s, 0); if (s[0]) m_data = v[7:0]; end
        1: begin wb(1'b1, 1, v, s, 0); if (s[0]) m_oeb = v[7:0]; end
        2: begin
          wb(1'b1, 3, v, s, 0);
          if (s[0]) m_div[7:0]  = v[7:0];
          if (s[1]) m_div[15:8] = v[15:8];
        end
        3: begin
          v[0] = 1'b0;
          wb(1'b1, 2, v, s, 0);
          if (s[0] && v[1]) m_done = 1'b0;
        end
        default: begin
          int w;
          w = $urandom_range(0, 7);
          if (w == 4) begin
            io_in = 8'($urandom); m_in = io_in;
            repeat (3) @(negedge clock);
          end
          rd(w);
        end
      endcase
      pins("rand");
    end

    repeat (3) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
